// File: rtl/serial_to_parallel_pkg.sv
// serial_to_parallel_pkg: definitions shared by the serial-to-parallel block.
//   cnt_width(depth) - width of a counter that must reach the value depth.
//   RST_BIT          - reset value of every data bit; the data word resets to
//                      this bit replicated, giving all zeros.
package serial_to_parallel_pkg;

  localparam logic RST_BIT = 1'b0;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/serial_to_parallel_if.sv
// serial_to_parallel_if: serial load bus for serial_to_parallel.
//   data_in - serial bit, taken while en=1
//   en      - shift enable
//   data    - parallel word, data[0] newest bit
//   full    - word completely loaded since reset
//             (present only with SERIAL_TO_PARALLEL_FILL_COUNT_EN)
// Modports: master drives the stream, slave is the shift register.
interface serial_to_parallel_if #(parameter int DEPTH = 8);
  logic             data_in;
  logic             en;
  logic [DEPTH-1:0] data;
`ifdef SERIAL_TO_PARALLEL_FILL_COUNT_EN
  logic             full;

  modport master (output data_in, output en, input data, input full);
  modport slave  (input data_in, input en, output data, output full);
`else
  modport master (output data_in, output en, input data);
  modport slave  (input data_in, input en, output data);
`endif
endinterface

// File: rtl/serial_to_parallel_sat_counter.sv
// sat_counter: counts inc_i pulses, saturating at MAX, and flags saturation.
//   clk    - clock
//   rst    - async active-low reset
//   inc_i  - count one event
//   full_o - registered, high once the count has reached MAX
module sat_counter #(
  parameter int MAX = 8,
  parameter int W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  output logic full_o
);
  logic [W-1:0] count_q, count_d;
  logic         full_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != W'(MAX))) count_d = count_q + W'(1);
  end

  // full is taken from the next count so it rises on the same edge as the
  // MAX-th increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == W'(MAX));
    end
  end

  assign full_o = full_q;
endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: serial-in, parallel-out shift register.
//   clk - clock, state changes on rising edge
//   rst - async active-low reset, clears the word immediately
//   bus - serial_to_parallel_if.slave (data_in, en, data[, full])
// Each enabled edge shifts the word up one bit and inserts data_in at bit 0;
// the oldest bit drops off the MSB. data is a pure register output.
// Build option: SERIAL_TO_PARALLEL_FILL_COUNT_EN adds the full flag.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_to_parallel_if.slave  bus
);
  logic [DEPTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (bus.en) data_d = {data_q[DEPTH-2:0], bus.data_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= {DEPTH{RST_BIT}};
    else      data_q <= data_d;
  end

  assign bus.data = data_q;

`ifdef SERIAL_TO_PARALLEL_FILL_COUNT_EN
  sat_counter #(
    .MAX (DEPTH),
    .W   (cnt_width(DEPTH))
  ) u_fill (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (bus.en),
    .full_o (bus.full)
  );
`endif
endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed and random checks of serial_to_parallel
// (DEPTH=3) against a bit-history model of the serial stream.
module tb_serial_to_parallel;
  localparam int DEPTH = 3;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  bit   hist[$];     // serial bits since reset, newest first
  int   shifts = 0;  // enabled shifts since reset

  serial_to_parallel_if #(.DEPTH(DEPTH)) bus ();

  serial_to_parallel #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DEPTH-1:0] model_word();
    logic [DEPTH-1:0] w = '0;
    for (int i = 0; i < hist.size() && i < DEPTH; i++) w[i] = hist[i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DEPTH-1:0] obs, input logic [DEPTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_full(input string tag);
`ifdef SERIAL_TO_PARALLEL_FILL_COUNT_EN
    logic exp_full;
    exp_full = (shifts >= DEPTH);
    vectors++;
    assert (bus.full === exp_full) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.full, exp_full);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Called just after a falling edge: drive, clock once, check at next fall.
  task automatic step(input logic e, input logic d, input string tag);
    bus.en = e;
    bus.data_in = d;
    @(posedge clk);
    if (rst && e) begin
      hist.push_front(d);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      if (shifts < DEPTH) shifts++;
    end
    @(negedge clk);
    chk(tag, bus.data, model_word());
    chk_full({tag, "_full"});
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    hist.delete();
    shifts = 0;
    #1;
    chk(tag, bus.data, '0);
    chk_full({tag, "_full"});
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b0;
    bus.data_in = 1'b0;
    #1;
    chk("reset_noclk", bus.data, 3'b000);
    chk_full("reset_noclk_full");
    @(negedge clk);
    rst = 1'b1;

    step(1'b0, 1'b1, "hold_after_reset");
    chk("hold_after_reset_k", bus.data, 3'b000);
    step(1'b1, 1'b1, "shift1");
    chk("shift1_k", bus.data, 3'b001);
    step(1'b1, 1'b0, "shift2");
    chk("shift2_k", bus.data, 3'b010);
    step(1'b1, 1'b1, "shift3");
    chk("shift3_k", bus.data, 3'b101);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, "hold");
      chk("hold_k", bus.data, 3'b101);
    end

    do_reset("reset_clear");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "ones");
    chk("msb_discard_k", bus.data, 3'b111);
    do_reset("reset_midstream");
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(39) == 0) begin
        do_reset("rand_reset");
        @(negedge clk);
        rst = 1'b1;
      end else begin
        step(1'($urandom_range(1)), 1'($urandom_range(1)), "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
